// File: rtl/proc_trace_pkg.sv
// rtl/proc_trace_pkg.sv - shared types for the processor trace checker
package proc_trace_pkg;

   // Stored entry widths; the checker's AW/DW must not exceed these.
   localparam int TRACE_AW = 32;
   localparam int TRACE_DW = 32;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_ADDR    = 2'd1,
      ERR_DATA    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_PASS = 2'd2,
      ST_FAIL = 2'd3
   } state_t;

   typedef struct packed {
      logic [TRACE_AW-1:0] addr;
      logic [TRACE_DW-1:0] data;
      logic                dc;
   } trace_entry_t;

endpackage

// File: rtl/proc_trace_fifo.sv
// rtl/proc_trace_fifo.sv - circular FIFO of expected trace entries
module proc_trace_fifo
   import proc_trace_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  trace_entry_t             wr_entry,
   output trace_entry_t             rd_entry,
   output logic                     push_acc,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);

   trace_entry_t   mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic           pop_acc;

   assign full     = (count == (PW+1)'(DEPTH));
   assign empty    = (count == '0);
   assign pop_acc  = pop && !empty;
   // A full FIFO still takes a push when the head leaves in the same cycle.
   assign push_acc = push && (!full || pop_acc);
   assign rd_entry = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push_acc) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_acc) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop_acc) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_acc, pop_acc})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/proc_trace_checker.sv
// rtl/proc_trace_checker.sv - compares retired instructions against an expected-entry queue
module proc_trace_checker
   import proc_trace_pkg::*;
#(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int DEPTH   = 16,
   parameter int TIMEOUT = 64,
   parameter int CW      = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            exp_val,
   output logic            exp_rdy,
   input  logic [AW-1:0]   exp_addr,
   input  logic [DW-1:0]   exp_data,
   input  logic            exp_dc,
   input  logic            start,
   input  logic            trace_val,
   input  logic [AW-1:0]   trace_addr,
   input  logic [DW-1:0]   trace_data,
   output logic            done,
   output logic            pass,
   output logic [1:0]      err_code,
   output logic [CW-1:0]   err_idx,
   output logic [AW-1:0]   err_addr,
   output logic [DW-1:0]   err_data,
   output logic [CW-1:0]   num_checked,
   output logic [CW-1:0]   cycles
);

   localparam int TW  = $clog2(TIMEOUT + 1);
   localparam int CNW = $clog2(DEPTH) + 1;

   state_t              state;
   err_code_t           err_q;
   trace_entry_t        wr_entry;
   trace_entry_t        head;
   logic                push_acc;
   logic                full;
   logic                empty;
   logic [CNW-1:0]      count;
   logic [TW-1:0]       tmo;
   logic                active;
   logic                pop;
   logic                addr_bad;
   logic                data_bad;

   assign active   = (state == ST_IDLE) || (state == ST_RUN);
   assign pop      = (state == ST_RUN) && trace_val;
   assign wr_entry = '{addr: TRACE_AW'(exp_addr), data: TRACE_DW'(exp_data), dc: exp_dc};
   assign addr_bad = (head.addr[AW-1:0] != trace_addr);
   assign data_bad = !head.dc && (head.data[DW-1:0] != trace_data);

   proc_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (exp_val && active),
      .pop      (pop),
      .wr_entry (wr_entry),
      .rd_entry (head),
      .push_acc (push_acc),
      .full     (full),
      .empty    (empty),
      .count    (count)
   );

   assign exp_rdy  = !full;
   assign done     = (state == ST_PASS) || (state == ST_FAIL);
   assign pass     = (state == ST_PASS);
   assign err_code = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         err_q       <= ERR_NONE;
         err_idx     <= '0;
         err_addr    <= '0;
         err_data    <= '0;
         num_checked <= '0;
         cycles      <= '0;
         tmo         <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_RUN;
                  tmo   <= '0;
               end
            end
            ST_RUN: begin
               if (cycles != '1) begin
                  cycles <= cycles + 1'b1;
               end
               tmo <= trace_val ? '0 : tmo + 1'b1;
               // An empty queue with nothing arriving means every entry has been seen.
               if (empty) begin
                  if (!push_acc) begin
                     state <= ST_PASS;
                  end
               end else if (trace_val) begin
                  if (addr_bad || data_bad) begin
                     state    <= ST_FAIL;
                     err_q    <= addr_bad ? ERR_ADDR : ERR_DATA;
                     err_idx  <= num_checked;
                     err_addr <= trace_addr;
                     err_data <= trace_data;
                  end else begin
                     num_checked <= num_checked + 1'b1;
                     if (count == CNW'(1) && !push_acc) begin
                        state <= ST_PASS;
                     end
                  end
               end else if (tmo == TW'(TIMEOUT - 1)) begin
                  state    <= ST_FAIL;
                  err_q    <= ERR_TIMEOUT;
                  err_idx  <= num_checked;
                  err_addr <= '0;
                  err_data <= '0;
               end
            end
            default: begin
               state <= state;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_proc_trace_checker.sv
// tb/tb_proc_trace_checker.sv - directed bench for proc_trace_checker
module tb_proc_trace_checker;

   logic        clk = 1'b0;
   logic        rst;
   logic        exp_val;
   logic        exp_rdy;
   logic [31:0] exp_addr;
   logic [31:0] exp_data;
   logic        exp_dc;
   logic        start;
   logic        trace_val;
   logic [31:0] trace_addr;
   logic [31:0] trace_data;
   logic        done;
   logic        pass;
   logic [1:0]  err_code;
   logic [15:0] err_idx;
   logic [31:0] err_addr;
   logic [31:0] err_data;
   logic [15:0] num_checked;
   logic [15:0] cycles;

   int checks   = 0;
   int failures = 0;

   proc_trace_checker #(
      .AW(32), .DW(32), .DEPTH(4), .TIMEOUT(8), .CW(16)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .exp_val     (exp_val),
      .exp_rdy     (exp_rdy),
      .exp_addr    (exp_addr),
      .exp_data    (exp_data),
      .exp_dc      (exp_dc),
      .start       (start),
      .trace_val   (trace_val),
      .trace_addr  (trace_addr),
      .trace_data  (trace_data),
      .done        (done),
      .pass        (pass),
      .err_code    (err_code),
      .err_idx     (err_idx),
      .err_addr    (err_addr),
      .err_data    (err_data),
      .num_checked (num_checked),
      .cycles      (cycles)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic idle_inputs();
      exp_val    = 1'b0;
      exp_addr   = '0;
      exp_data   = '0;
      exp_dc     = 1'b0;
      start      = 1'b0;
      trace_val  = 1'b0;
      trace_addr = '0;
      trace_data = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic push(input logic [31:0] a, input logic [31:0] d, input logic dc);
      exp_val  = 1'b1;
      exp_addr = a;
      exp_data = d;
      exp_dc   = dc;
      tick();
      exp_val  = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic trace(input logic [31:0] a, input logic [31:0] d);
      trace_val  = 1'b1;
      trace_addr = a;
      trace_data = d;
      tick();
      trace_val  = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      #1;
      do_reset();

      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err_code", err_code, 0);
      chk("rst_err_idx", err_idx, 0);
      chk("rst_err_addr", err_addr, 0);
      chk("rst_err_data", err_data, 0);
      chk("rst_num_checked", num_checked, 0);
      chk("rst_cycles", cycles, 0);
      chk("rst_exp_rdy", exp_rdy, 1);

      // Three matching traces, the last with a don't-care data field.
      push(32'h200, 32'h2, 1'b0);
      push(32'h204, 32'h3, 1'b0);
      push(32'h208, 32'h0, 1'b1);
      do_start();
      trace(32'h200, 32'h2);
      trace(32'h204, 32'h3);
      chk("t1_not_done_yet", done, 0);
      trace(32'h208, 32'hdead);
      chk("t1_done", done, 1);
      chk("t1_pass", pass, 1);
      chk("t1_num_checked", num_checked, 3);
      chk("t1_err_code", err_code, 0);
      chk("t1_cycles", cycles, 3);
      tick();
      chk("t1_cycles_frozen", cycles, 3);
      chk("t1_pass_sticky", pass, 1);

      // Data mismatch on the first entry.
      do_reset();
      push(32'h200, 32'h5, 1'b0);
      do_start();
      trace(32'h200, 32'h6);
      chk("t2_done", done, 1);
      chk("t2_pass", pass, 0);
      chk("t2_err_code", err_code, 2);
      chk("t2_err_idx", err_idx, 0);
      chk("t2_err_addr", err_addr, 32'h200);
      chk("t2_err_data", err_data, 32'h6);
      trace(32'h200, 32'h5);
      chk("t2_err_code_hold", err_code, 2);
      chk("t2_err_data_hold", err_data, 32'h6);
      chk("t2_num_checked_hold", num_checked, 0);
      chk("t2_pass_hold", pass, 0);

      // Taken branch: second address differs.
      do_reset();
      push(32'h200, 32'h0, 1'b1);
      push(32'h208, 32'h0, 1'b1);
      do_start();
      trace(32'h200, 32'h11);
      trace(32'h204, 32'h22);
      chk("t3_done", done, 1);
      chk("t3_err_code", err_code, 1);
      chk("t3_err_idx", err_idx, 1);
      chk("t3_err_addr", err_addr, 32'h204);
      chk("t3_err_data", err_data, 32'h22);
      chk("t3_num_checked", num_checked, 1);

      // Silence after one trace trips the timeout exactly 8 edges later.
      do_reset();
      push(32'h300, 32'h0, 1'b1);
      push(32'h304, 32'h0, 1'b1);
      do_start();
      trace(32'h300, 32'h0);
      for (int i = 0; i < 7; i++) tick();
      chk("t4_not_yet", done, 0);
      tick();
      chk("t4_done", done, 1);
      chk("t4_err_code", err_code, 3);
      chk("t4_err_idx", err_idx, 1);
      chk("t4_err_addr", err_addr, 0);
      chk("t4_err_data", err_data, 0);

      // DEPTH=4: overflow drop, full push+pop, 10-entry stream with wrap.
      do_reset();
      for (int i = 0; i < 4; i++) push(32'h400 + 32'(4 * i), 32'(i), 1'b0);
      chk("t5_full_rdy", exp_rdy, 0);
      push(32'hbad0, 32'hbad, 1'b0);
      chk("t5_drop_rdy", exp_rdy, 0);
      do_start();
      exp_val  = 1'b1;
      exp_addr = 32'h410;
      exp_data = 32'd4;
      exp_dc   = 1'b0;
      trace(32'h400, 32'd0);
      exp_val  = 1'b0;
      chk("t5_full_pushpop_rdy", exp_rdy, 0);
      chk("t5_first_checked", num_checked, 1);
      for (int i = 1; i < 10; i++) begin
         if (i + 4 <= 9) begin
            exp_val  = 1'b1;
            exp_addr = 32'h400 + 32'(4 * (i + 4));
            exp_data = 32'(i + 4);
         end
         trace(32'h400 + 32'(4 * i), 32'(i));
         exp_val = 1'b0;
         if (i == 6) chk("t5_rdy_after_drain", exp_rdy, 1);
         if (i == 8) chk("t5_not_done_at_9", done, 0);
      end
      chk("t5_pass", pass, 1);
      chk("t5_num_checked", num_checked, 10);
      chk("t5_err_code", err_code, 0);

      // Reset wins over same-cycle trace, push and start.
      do_reset();
      push(32'h500, 32'h1, 1'b0);
      push(32'h504, 32'h2, 1'b0);
      do_start();
      rst        = 1'b1;
      trace_val  = 1'b1;
      trace_addr = 32'h500;
      trace_data = 32'h1;
      exp_val    = 1'b1;
      exp_addr   = 32'h508;
      start      = 1'b1;
      tick();
      rst = 1'b0;
      idle_inputs();
      chk("t6_done", done, 0);
      chk("t6_pass", pass, 0);
      chk("t6_num_checked", num_checked, 0);
      chk("t6_cycles", cycles, 0);
      chk("t6_exp_rdy", exp_rdy, 1);
      chk("t6_err_code", err_code, 0);
      do_start();
      chk("t6_running", done, 0);
      tick();
      chk("t6_empty_pass", pass, 1);
      chk("t6_empty_checked", num_checked, 0);
      chk("t6_empty_cycles", cycles, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
